// File: rtl/rgmii_pkg.sv
// Shared definitions for the RGMII transmit path: speed encodings, TXC period
// constants and the packed per-half pin bundle.
package rgmii_pkg;

    typedef enum logic [1:0] {
        Spd10   = 2'b00,
        Spd100  = 2'b01,
        Spd1000 = 2'b10
    } speed_e;

    localparam int unsigned Period100   = 5;
    localparam int unsigned Period10    = 50;
    // Last cnt value with TXC high in the first half of the cycle.
    localparam int unsigned HighLast100 = 2;
    localparam int unsigned HighLast10  = 24;

    typedef struct packed {
        logic       txc;
        logic [3:0] txd;
        logic       ctl;
    } pin_t;

    function automatic speed_e decode_speed(logic [1:0] s);
        if (s[1]) return Spd1000;
        return s[0] ? Spd100 : Spd10;
    endfunction

endpackage

// File: rtl/oddr.sv
// Behavioural DDR output register: d1 is driven while clk is high, d2 while clk is low.
// Both halves are registered on the rising edge and cleared by the async reset.
module oddr #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d1_i,
    input  logic [WIDTH-1:0] d2_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] d1_q;
    logic [WIDTH-1:0] d2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_q <= '0;
            d2_q <= '0;
        end else begin
            d1_q <= d1_i;
            d2_q <= d2_i;
        end
    end

    assign q_o = clk ? d1_q : d2_q;

endmodule

// File: rtl/rgmii_tx_if.sv
// RGMII transmit interface: GMII bytes to DDR TXD/TX_CTL plus forwarded TXC, with
// clock-enable pacing for 10M/100M. Define RGMII_TX_ER_EN to carry tx_er on TX_CTL.
module rgmii_tx_if
    import rgmii_pkg::*;
#(
    parameter int unsigned SPEED_W = 2,
    parameter int unsigned CNT_W   = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SPEED_W-1:0] speed_i,
    input  logic [7:0]         gmii_txd_i,
    input  logic               gmii_tx_en_i,
    input  logic               gmii_tx_er_i,
    output logic               gmii_clk_en_o,
    output logic               rgmii_txc_o,
    output logic [3:0]         rgmii_txd_o,
    output logic               rgmii_tx_ctl_o
);

    logic [SPEED_W-1:0] speed_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_last;
    logic               nib_sel_q, nib_sel_d;
    logic [7:0]         hold_data_q, hold_data_d;
    logic               hold_en_q, hold_en_d;
    pin_t               enc_d1_q, enc_d1_d, enc_d2_q, enc_d2_d;
    pin_t               pins;
    speed_e             mode;
    logic               speed_chg, period_end, clk_en, ctl_lo;
    logic               hi1, hi2;
    logic [3:0]         nib;

    assign mode       = decode_speed(speed_q);
    assign speed_chg  = (speed_i != speed_q);
    assign period_end = (cnt_q == cnt_last);
    assign clk_en     = !speed_chg && ((mode == Spd1000) || (period_end && nib_sel_q));

    always_comb begin
        cnt_last = '0;
        case (mode)
            Spd100:  cnt_last = CNT_W'(Period100 - 1);
            Spd10:   cnt_last = CNT_W'(Period10 - 1);
            default: cnt_last = '0;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        nib_sel_d   = nib_sel_q;
        hold_data_d = hold_data_q;
        hold_en_d   = hold_en_q;
        if (speed_chg) begin
            cnt_d       = '0;
            nib_sel_d   = 1'b0;
            hold_data_d = '0;
            hold_en_d   = 1'b0;
        end else begin
            if (mode != Spd1000) begin
                if (period_end) begin
                    cnt_d     = '0;
                    nib_sel_d = ~nib_sel_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            if (clk_en) begin
                hold_data_d = gmii_txd_i;
                hold_en_d   = gmii_tx_en_i;
            end
        end
    end

`ifdef RGMII_TX_ER_EN
    logic hold_er_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_er_q <= 1'b0;
        end else if (speed_chg) begin
            hold_er_q <= 1'b0;
        end else if (clk_en) begin
            hold_er_q <= gmii_tx_er_i;
        end
    end
    assign ctl_lo = hold_en_q ^ hold_er_q;
`else
    logic unused_tx_er;
    assign unused_tx_er = gmii_tx_er_i;
    assign ctl_lo       = hold_en_q;
`endif

    // On a speed change both halves go idle, so TXC never carries a shortened pulse.
    always_comb begin
        enc_d1_d = '0;
        enc_d2_d = '0;
        hi1      = 1'b0;
        hi2      = 1'b0;
        nib      = nib_sel_q ? hold_data_q[7:4] : hold_data_q[3:0];
        if (!speed_chg) begin
            if (mode == Spd1000) begin
                enc_d1_d.txc = 1'b1;
                enc_d1_d.txd = hold_data_q[3:0];
                enc_d1_d.ctl = hold_en_q;
                enc_d2_d.txc = 1'b0;
                enc_d2_d.txd = hold_data_q[7:4];
                enc_d2_d.ctl = ctl_lo;
            end else begin
                if (mode == Spd100) begin
                    hi1 = (cnt_q <= CNT_W'(HighLast100));
                    hi2 = (cnt_q < CNT_W'(HighLast100));
                end else begin
                    hi1 = (cnt_q <= CNT_W'(HighLast10));
                    hi2 = hi1;
                end
                enc_d1_d.txc = hi1;
                enc_d1_d.txd = nib;
                enc_d1_d.ctl = hi1 ? hold_en_q : ctl_lo;
                enc_d2_d.txc = hi2;
                enc_d2_d.txd = nib;
                enc_d2_d.ctl = hi2 ? hold_en_q : ctl_lo;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed_q     <= '0;
            cnt_q       <= '0;
            nib_sel_q   <= 1'b0;
            hold_data_q <= '0;
            hold_en_q   <= 1'b0;
            enc_d1_q    <= '0;
            enc_d2_q    <= '0;
        end else begin
            speed_q     <= speed_i;
            cnt_q       <= cnt_d;
            nib_sel_q   <= nib_sel_d;
            hold_data_q <= hold_data_d;
            hold_en_q   <= hold_en_d;
            enc_d1_q    <= enc_d1_d;
            enc_d2_q    <= enc_d2_d;
        end
    end

    oddr #(
        .WIDTH(6)
    ) u_oddr (
        .clk  (clk),
        .rst_n(rst_n),
        .d1_i (enc_d1_q),
        .d2_i (enc_d2_q),
        .q_o  (pins)
    );

    assign gmii_clk_en_o  = clk_en;
    assign rgmii_txc_o    = pins.txc;
    assign rgmii_txd_o    = pins.txd;
    assign rgmii_tx_ctl_o = pins.ctl;

endmodule

// File: tb/tb_rgmii_tx_if.sv
// Directed bench for rgmii_tx_if: captured bytes push expected pin pairs into a
// scoreboard that is popped as the pins are sampled on both clock halves.
module tb_rgmii_tx_if;

    logic       clk;
    logic       rst_n;
    logic [1:0] speed_i;
    logic [7:0] gmii_txd_i;
    logic       gmii_tx_en_i;
    logic       gmii_tx_er_i;
    logic       gmii_clk_en_o;
    logic       rgmii_txc_o;
    logic [3:0] rgmii_txd_o;
    logic       rgmii_tx_ctl_o;

    typedef struct {
        int         due;
        logic [5:0] hi;
        logic [5:0] lo;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   last_cap = -1;
    int   tb_mode  = 2;
    int   c0;
    bit   track    = 1'b1;

    rgmii_tx_if #(
        .SPEED_W(2),
        .CNT_W  (6)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .speed_i       (speed_i),
        .gmii_txd_i    (gmii_txd_i),
        .gmii_tx_en_i  (gmii_tx_en_i),
        .gmii_tx_er_i  (gmii_tx_er_i),
        .gmii_clk_en_o (gmii_clk_en_o),
        .rgmii_txc_o   (rgmii_txc_o),
        .rgmii_txd_o   (rgmii_txd_o),
        .rgmii_tx_ctl_o(rgmii_tx_ctl_o)
    );

    initial begin
        clk = 1'b0;
        forever #4 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ctl_f(input logic txc, input logic en, input logic er);
`ifdef RGMII_TX_ER_EN
        return txc ? en : (en ^ er);
`else
        return en;
`endif
    endfunction

    task automatic push_exp(input int due, input logic [5:0] hi, input logic [5:0] lo);
        exp_t t;
        t.due = due;
        t.hi  = hi;
        t.lo  = lo;
        sb.push_back(t);
    endtask

    // Expected pin pairs for one captured byte, from the documented TXC tables.
    task automatic push_byte(input logic [7:0] d, input logic e, input logic r);
        int         per;
        int         c;
        logic       th, tl;
        logic [3:0] lo_n, hi_n, n;
        lo_n = d[3:0];
        hi_n = d[7:4];
        if (tb_mode == 2) begin
            push_exp(cyc + 2, {1'b1, lo_n, e}, {1'b0, hi_n, ctl_f(1'b0, e, r)});
        end else begin
            per = (tb_mode == 1) ? 5 : 50;
            for (int j = 0; j < 2 * per; j++) begin
                c = j % per;
                n = (j < per) ? lo_n : hi_n;
                if (tb_mode == 1) begin
                    th = (c < 3);
                    tl = (c < 2);
                end else begin
                    th = (c < 25);
                    tl = th;
                end
                push_exp(cyc + 2 + j, {th, n, ctl_f(th, e, r)}, {tl, n, ctl_f(tl, e, r)});
            end
        end
    endtask

    task automatic tick();
        logic       en_pre;
        logic [7:0] d;
        logic       e, r;
        #1;
        en_pre = gmii_clk_en_o;
        d      = gmii_txd_i;
        e      = gmii_tx_en_i;
        r      = gmii_tx_er_i;
        @(posedge clk);
        cyc++;
        if (en_pre === 1'b1) begin
            last_cap = cyc;
            if (track) push_byte(d, e, r);
        end
        #1;
        while (sb.size() > 0 && sb[0].due < cyc) begin
            check("stale_entry", sb[0].due, cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].due == cyc)
            check($sformatf("pins_hi@%0d", cyc), {rgmii_txc_o, rgmii_txd_o, rgmii_tx_ctl_o},
                  sb[0].hi);
        @(negedge clk);
        #1;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            check($sformatf("pins_lo@%0d", cyc), {rgmii_txc_o, rgmii_txd_o, rgmii_tx_ctl_o},
                  sb[0].lo);
            void'(sb.pop_front());
        end
    endtask

    task automatic send(input logic [7:0] d, input logic e, input logic r);
        int n;
        gmii_txd_i   = d;
        gmii_tx_en_i = e;
        gmii_tx_er_i = r;
        n = 0;
        do begin
            tick();
            n++;
        end while (last_cap != cyc && n < 200);
        if (last_cap != cyc) check("capture_timeout", last_cap, cyc);
    endtask

    task automatic change_speed(input logic [1:0] s, input int mode);
        int e;
        speed_i = s;
        #1;
        check("clk_en_on_change", gmii_clk_en_o, 0);
        tick();
        e = cyc;
        while (sb.size() > 0 && sb[sb.size() - 1].due > e) void'(sb.pop_back());
        tb_mode = mode;
    endtask

    initial begin
        rst_n        = 1'b0;
        speed_i      = 2'b10;
        gmii_txd_i   = 8'h00;
        gmii_tx_en_i = 1'b0;
        gmii_tx_er_i = 1'b0;
        tb_mode      = 2;
        repeat (3) @(negedge clk);
        #1;
        check("rst_clk_en", gmii_clk_en_o, 0);
        check("rst_txc", rgmii_txc_o, 0);
        check("rst_txd", rgmii_txd_o, 0);
        check("rst_ctl", rgmii_tx_ctl_o, 0);

        // 1000M
        rst_n = 1'b1;
        cyc   = 0;
        send(8'h5D, 1'b1, 1'b0);
        check("first_en_1000", last_cap, 2);
        send(8'hA7, 1'b1, 1'b0);
        send(8'h3C, 1'b1, 1'b1);
        send(8'h00, 1'b0, 1'b0);

        // 100M
        c0 = cyc;
        change_speed(2'b01, 1);
        send(8'h3C, 1'b1, 1'b0);
        check("first_en_100", last_cap, c0 + 11);
        c0 = last_cap;
        send(8'h96, 1'b1, 1'b0);
        check("period_100", last_cap - c0, 10);
        repeat (3) tick();

        // 100M -> 1000M mid-byte
        c0 = cyc;
        change_speed(2'b10, 2);
        check("clk_en_after_change", gmii_clk_en_o, 1);
        push_exp(c0 + 2, 6'b000000, 6'b000000);
        push_exp(c0 + 3, {1'b1, 4'h0, 1'b0}, 6'b000000);
        send(8'hF0, 1'b1, 1'b0);
        check("first_en_gig_after_change", last_cap, c0 + 2);
        send(8'h00, 1'b0, 1'b0);

        // 10M: idle, then a two-byte frame
        c0 = cyc;
        change_speed(2'b00, 0);
        send(8'h00, 1'b0, 1'b0);
        check("first_en_10", last_cap, c0 + 101);
        c0 = last_cap;
        send(8'hE1, 1'b1, 1'b0);
        check("period_10", last_cap - c0, 100);
        send(8'h4B, 1'b1, 1'b0);
        send(8'h00, 1'b0, 1'b0);

        // Reset mid-frame at 10M
        send(8'h77, 1'b1, 1'b0);
        repeat (30) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_clk_en", gmii_clk_en_o, 0);
        check("midrst_txc", rgmii_txc_o, 0);
        check("midrst_txd", rgmii_txd_o, 0);
        check("midrst_ctl", rgmii_tx_ctl_o, 0);
        sb.delete();
        repeat (2) tick();
        speed_i = 2'b01;
        tb_mode = 1;
        rst_n   = 1'b1;
        cyc     = 0;
        send(8'h55, 1'b1, 1'b0);
        check("first_en_after_rst_100", last_cap, 11);
        track        = 1'b0;
        gmii_txd_i   = 8'h00;
        gmii_tx_en_i = 1'b0;
        repeat (12) tick();
        check("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
